// File: rtl/periph_sdram_arb_pkg.sv
// Shared definitions for the peripheral SDRAM arbiter: FSM encoding and arbitration modes.
package periph_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/periph_sdram_arb_if.sv
// Single peripheral SDRAM command port toward the core SDRAM arbiter.
interface periph_sdram_arb_if #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 3
);
  logic                  mux_rd;
  logic                  mux_wr;
  logic [ADDR_W-1:0]     mux_addr;
  logic [DATA_W-1:0]     mux_wdata;
  logic [DATA_W/8-1:0]   mux_wstrb;
  logic [BURST_W-1:0]    mux_burst_len;
  logic                  mux_ack;
  logic                  mux_done;

  modport master (
    output mux_rd, mux_wr, mux_addr, mux_wdata, mux_wstrb, mux_burst_len,
    input  mux_ack, mux_done
  );

  modport slave (
    input  mux_rd, mux_wr, mux_addr, mux_wdata, mux_wstrb, mux_burst_len,
    output mux_ack, mux_done
  );
endinterface

// File: rtl/periph_sdram_arb_pick.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin from rr_ptr.
module periph_arb_pick
  import periph_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend,
  input  logic [IDX_W-1:0]  rr_ptr,
  input  logic              rr_mode,
  output logic [NUM_CH-1:0] win_onehot,
  output logic [IDX_W-1:0]  win_idx,
  output logic              win_valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the start index; the first pending candidate wins.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand     = rr_mode ? ((int'(rr_ptr) + k) % NUM_CH) : k;
      cand_idx = IDX_W'(cand);
      if (!win_valid && pend[cand_idx]) begin
        win_valid            = 1'b1;
        win_idx              = cand_idx;
        win_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_sdram_arb.sv
// N-channel request merger onto the peripheral SDRAM port; one registered command in flight.
//   state | meaning
//   IDLE  | no owner; pick a winner from pending channels and latch its command
//   ISSUE | command presented downstream, held until mux_ack
//   WAIT  | command accepted, waiting for mux_done to release the owner
module periph_sdram_arb
  import periph_arb_pkg::*;
#(
  parameter int                 NUM_CH     = 3,
  parameter int                 ADDR_W     = 24,
  parameter int                 DATA_W     = 32,
  parameter int                 BURST_W    = 3,
  parameter int                 ARB_MODE   = ARB_FIXED,
  parameter logic [NUM_CH-1:0]  BURST_MASK = '1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            ch_rd,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0]   ch_wstrb,
  input  logic [NUM_CH*BURST_W-1:0]    ch_burst_len,
  input  logic [NUM_CH-1:0]            ch_active,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [NUM_CH-1:0]            ch_done,
  output logic                         mux_active,
  periph_sdram_arb_if.master           sdram
);

  localparam int   IDX_W   = $clog2(NUM_CH);
  localparam int   STRB_W  = DATA_W / 8;
  localparam logic RR_MODE = (ARB_MODE == ARB_RR);

  arb_state_t          state_q, state_d;
  logic [NUM_CH-1:0]   pend, win_onehot, grant_d;
  logic [IDX_W-1:0]    win_idx, idx_q, idx_d, rr_q, rr_d, rr_next;
  logic                win_valid;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [BURST_W-1:0]  blen_q, blen_d;

  logic [ADDR_W-1:0]   addr_a  [NUM_CH];
  logic [DATA_W-1:0]   wdata_a [NUM_CH];
  logic [STRB_W-1:0]   wstrb_a [NUM_CH];
  logic [BURST_W-1:0]  blen_a  [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_a[i]  = ch_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = ch_wdata[i*DATA_W +: DATA_W];
    assign wstrb_a[i] = ch_wstrb[i*STRB_W +: STRB_W];
    assign blen_a[i]  = ch_burst_len[i*BURST_W +: BURST_W];
  end

  assign pend = ch_rd | ch_wr;

  periph_arb_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .pend       (pend),
    .rr_ptr     (rr_q),
    .rr_mode    (RR_MODE),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  assign rr_next = (idx_q == IDX_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = ch_grant;
    idx_d   = idx_q;
    rr_d    = rr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    blen_d  = blen_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_onehot;
          idx_d   = win_idx;
          // A channel raising both rd and wr is forwarded as a read.
          rd_d    = ch_rd[win_idx];
          wr_d    = ch_wr[win_idx] & ~ch_rd[win_idx];
          addr_d  = addr_a[win_idx];
          wdata_d = wdata_a[win_idx];
          wstrb_d = wstrb_a[win_idx];
          blen_d  = blen_a[win_idx] & {BURST_W{BURST_MASK[win_idx]}};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (sdram.mux_ack) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (sdram.mux_done) begin
            grant_d = '0;
            state_d = IDLE;
            if (RR_MODE) rr_d = rr_next;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdram.mux_done) begin
          grant_d = '0;
          state_d = IDLE;
          if (RR_MODE) rr_d = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ch_grant <= '0;
      idx_q    <= '0;
      rr_q     <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      blen_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_grant <= grant_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      blen_q   <= blen_d;
    end
  end

  // Handshake pulses are gated by state so stray ack/done in IDLE never reach a channel.
  assign ch_ack  = {NUM_CH{(state_q == ISSUE) && sdram.mux_ack}} & ch_grant;
  assign ch_done = {NUM_CH{sdram.mux_done &&
                   ((state_q == WAIT) || ((state_q == ISSUE) && sdram.mux_ack))}} & ch_grant;

  assign mux_active          = |ch_active;
  assign sdram.mux_rd        = rd_q;
  assign sdram.mux_wr        = wr_q;
  assign sdram.mux_addr      = addr_q;
  assign sdram.mux_wdata     = wdata_q;
  assign sdram.mux_wstrb     = wstrb_q;
  assign sdram.mux_burst_len = blen_q;

endmodule

// File: tb/tb_periph_sdram_arb.sv
// Bench for periph_sdram_arb: dut0 fixed priority with BURST_MASK 110, dut1 round-robin.
module tb_periph_sdram_arb;
  localparam int N = 3, AW = 24, DW = 32, BW = 3, SW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    rd [2], wr [2], active [2];
  logic [N*AW-1:0] addr [2];
  logic [N*DW-1:0] wdata [2];
  logic [N*SW-1:0] wstrb [2];
  logic [N*BW-1:0] blen [2];
  logic [N-1:0]    grant_o [2], ack_o [2], done_o [2];
  logic            mact_o [2];
  logic            o_rd [2], o_wr [2];
  logic [AW-1:0]   o_addr [2];
  logic [DW-1:0]   o_wdata [2];
  logic [SW-1:0]   o_wstrb [2];
  logic [BW-1:0]   o_blen [2];
  logic            m_ack [2], m_done [2];

  periph_sdram_arb_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) bus0 ();
  periph_sdram_arb_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) bus1 ();

  assign bus0.mux_ack = m_ack[0];  assign bus0.mux_done = m_done[0];
  assign bus1.mux_ack = m_ack[1];  assign bus1.mux_done = m_done[1];
  assign o_rd[0] = bus0.mux_rd;    assign o_rd[1] = bus1.mux_rd;
  assign o_wr[0] = bus0.mux_wr;    assign o_wr[1] = bus1.mux_wr;
  assign o_addr[0] = bus0.mux_addr;   assign o_addr[1] = bus1.mux_addr;
  assign o_wdata[0] = bus0.mux_wdata; assign o_wdata[1] = bus1.mux_wdata;
  assign o_wstrb[0] = bus0.mux_wstrb; assign o_wstrb[1] = bus1.mux_wstrb;
  assign o_blen[0] = bus0.mux_burst_len; assign o_blen[1] = bus1.mux_burst_len;

  periph_sdram_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW),
                     .ARB_MODE(0), .BURST_MASK(3'b110)) dut0 (
    .clk(clk), .reset_n(reset_n), .ch_rd(rd[0]), .ch_wr(wr[0]), .ch_addr(addr[0]),
    .ch_wdata(wdata[0]), .ch_wstrb(wstrb[0]), .ch_burst_len(blen[0]), .ch_active(active[0]),
    .ch_grant(grant_o[0]), .ch_ack(ack_o[0]), .ch_done(done_o[0]), .mux_active(mact_o[0]),
    .sdram(bus0)
  );

  periph_sdram_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW),
                     .ARB_MODE(1), .BURST_MASK(3'b111)) dut1 (
    .clk(clk), .reset_n(reset_n), .ch_rd(rd[1]), .ch_wr(wr[1]), .ch_addr(addr[1]),
    .ch_wdata(wdata[1]), .ch_wstrb(wstrb[1]), .ch_burst_len(blen[1]), .ch_active(active[1]),
    .ch_grant(grant_o[1]), .ch_ack(ack_o[1]), .ch_done(done_o[1]), .mux_active(mact_o[1]),
    .sdram(bus1)
  );

  int tests = 0;
  int fails = 0;

  // Transaction-level model: who owns the port, whether the command was accepted, rr pointer.
  bit            m_own [2], m_acc [2], m_erd [2], m_ewr [2];
  int            m_g [2], m_ptr [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [SW-1:0] m_wstrb [2];
  logic [BW-1:0] m_blen [2];
  bit            req_on [2][N], saw_ack [2][N];

  function automatic logic [N-1:0] mask_of(input int d);
    return (d == 0) ? 3'b110 : 3'b111;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = 0; m_acc[d] = 0; m_erd[d] = 0; m_ewr[d] = 0;
      m_g[d] = 0; m_ptr[d] = 0;
      m_addr[d] = '0; m_wdata[d] = '0; m_wstrb[d] = '0; m_blen[d] = '0;
    end
  endtask

  function automatic int pick(input int d);
    int p;
    int j;
    p = int'(rd[d] | wr[d]);
    for (int k = 0; k < N; k++) begin
      j = (d == 1) ? (m_ptr[d] + k) % N : k;
      if (((p >> j) & 1) == 1) return j;
    end
    return -1;
  endfunction

  task automatic release_owner(input int d);
    m_own[d] = 0;
    m_acc[d] = 0;
    if (d == 1) m_ptr[d] = (m_g[d] + 1) % N;
  endtask

  task automatic model_edge(input int d);
    int w;
    bit r;
    if (!m_own[d]) begin
      w = pick(d);
      if (w >= 0) begin
        r          = ((int'(rd[d]) >> w) & 1) == 1;
        m_own[d]   = 1;
        m_acc[d]   = 0;
        m_g[d]     = w;
        m_erd[d]   = r;
        m_ewr[d]   = !r && (((int'(wr[d]) >> w) & 1) == 1);
        m_addr[d]  = AW'(addr[d] >> (w * AW));
        m_wdata[d] = DW'(wdata[d] >> (w * DW));
        m_wstrb[d] = SW'(wstrb[d] >> (w * SW));
        m_blen[d]  = ((int'(mask_of(d)) >> w) & 1) == 1 ? BW'(blen[d] >> (w * BW)) : '0;
      end
    end else if (!m_acc[d]) begin
      if (m_ack[d]) begin
        if (m_done[d]) release_owner(d);
        else m_acc[d] = 1;
      end
    end else if (m_done[d]) begin
      release_owner(d);
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] eg, ea, ed;
      eg = m_own[d] ? N'(1 << m_g[d]) : '0;
      ea = (m_own[d] && !m_acc[d] && m_ack[d]) ? eg : '0;
      ed = (m_own[d] && m_done[d] && (m_acc[d] || m_ack[d])) ? eg : '0;
      chk("grant", d, grant_o[d], eg);
      chk("mux_rd", d, o_rd[d], m_own[d] && !m_acc[d] && m_erd[d]);
      chk("mux_wr", d, o_wr[d], m_own[d] && !m_acc[d] && m_ewr[d]);
      chk("mux_addr", d, o_addr[d], m_addr[d]);
      chk("mux_wdata", d, o_wdata[d], m_wdata[d]);
      chk("mux_wstrb", d, o_wstrb[d], m_wstrb[d]);
      chk("mux_burst", d, o_blen[d], m_blen[d]);
      chk("ch_ack", d, ack_o[d], ea);
      chk("ch_done", d, done_o[d], ed);
      chk("mux_active", d, mact_o[d], |active[d]);
      for (int c = 0; c < N; c++)
        if (((int'(ea) >> c) & 1) == 1) saw_ack[d][c] = 1;
    end
  endtask

  task automatic cycle();
    #1;
    compare();
    @(posedge clk);
    if (reset_n) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
  endtask

  task automatic set_ch(input int d, input int c, input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [SW-1:0] ws, input logic [BW-1:0] bl);
    logic [N-1:0] m;
    m = N'(1) << c;
    rd[d] = r ? (rd[d] | m) : (rd[d] & ~m);
    wr[d] = w ? (wr[d] | m) : (wr[d] & ~m);
    addr[d][c*AW +: AW]  = a;
    wdata[d][c*DW +: DW] = wd;
    wstrb[d][c*SW +: SW] = ws;
    blen[d][c*BW +: BW]  = bl;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      rd[d] = '0; wr[d] = '0; active[d] = '0;
      addr[d] = '0; wdata[d] = '0; wstrb[d] = '0; blen[d] = '0;
      m_ack[d] = 1'b0; m_done[d] = 1'b0;
      for (int c = 0; c < N; c++) begin
        req_on[d][c] = 0; saw_ack[d][c] = 0;
      end
    end
  endtask

  task automatic ack_done_cycle(input int d);
    m_ack[d] = 1'b1; m_done[d] = 1'b1;
    cycle();
    m_ack[d] = 1'b0; m_done[d] = 1'b0;
  endtask

  task automatic rand_inputs();
    int k;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        if (req_on[d][c] && saw_ack[d][c]) begin
          rd[d] = rd[d] & ~(N'(1) << c);
          wr[d] = wr[d] & ~(N'(1) << c);
          req_on[d][c] = 0;
          saw_ack[d][c] = 0;
        end else if (!req_on[d][c] && $urandom_range(0, 3) == 0) begin
          k = $urandom_range(0, 7);
          set_ch(d, c, (k == 0) || (k >= 3), k < 3, AW'($urandom), $urandom,
                 SW'($urandom), BW'($urandom));
          req_on[d][c] = 1;
          saw_ack[d][c] = 0;
        end
      end
      if (m_own[d] && !m_acc[d]) begin
        m_ack[d]  = ($urandom_range(0, 1) == 1);
        m_done[d] = m_ack[d] && ($urandom_range(0, 3) == 0);
      end else if (m_own[d]) begin
        m_ack[d]  = 1'b0;
        m_done[d] = ($urandom_range(0, 2) == 0);
      end else begin
        m_ack[d]  = ($urandom_range(0, 7) == 0);
        m_done[d] = ($urandom_range(0, 7) == 0);
      end
      active[d] = N'($urandom);
    end
  endtask

  initial begin
    int owner;
    int order [5];
    order = '{0, 1, 2, 0, 1};
    clear_inputs();
    model_reset();
    @(negedge clk);
    cycle();
    #1;
    chk("reset_grant", 0, grant_o[0], 3'b000);
    chk("reset_rd", 1, o_rd[1], 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // mux_active and rd+wr collision
    active[0] = 3'b100;
    #1;
    chk("t6_active", 0, mact_o[0], 1'b1);
    chk("t6_idle_rd", 0, o_rd[0], 1'b0);
    chk("t6_idle_wr", 0, o_wr[0], 1'b0);
    cycle();
    set_ch(0, 1, 1, 1, 24'h000abc, 32'h11112222, 4'h3, 3'd0);
    cycle();
    chk("t6_both_rd", 0, o_rd[0], 1'b1);
    chk("t6_both_wr", 0, o_wr[0], 1'b0);
    ack_done_cycle(0);
    clear_inputs();
    cycle();

    // fixed priority: ch0 beats ch2
    set_ch(0, 0, 1, 0, 24'h000100, 32'h0, 4'h0, 3'd0);
    set_ch(0, 2, 1, 0, 24'h000200, 32'h0, 4'h0, 3'd0);
    cycle();
    chk("t1_grant", 0, grant_o[0], 3'b001);
    chk("t1_rd", 0, o_rd[0], 1'b1);
    chk("t1_addr", 0, o_addr[0], 24'h000100);
    m_ack[0] = 1'b1;
    #1;
    chk("t1_ack", 0, ack_o[0], 3'b001);
    cycle();
    m_ack[0] = 1'b0;
    set_ch(0, 0, 0, 0, 24'h000100, 32'h0, 4'h0, 3'd0);
    chk("t1_rd_clear", 0, o_rd[0], 1'b0);
    m_done[0] = 1'b1;
    #1;
    chk("t1_done", 0, done_o[0], 3'b001);
    cycle();
    m_done[0] = 1'b0;
    chk("t1_grant_free", 0, grant_o[0], 3'b000);
    cycle();
    chk("t1_grant2", 0, grant_o[0], 3'b100);
    chk("t1_addr2", 0, o_addr[0], 24'h000200);
    ack_done_cycle(0);
    clear_inputs();
    cycle();

    // ack and done together on a ch1 write
    set_ch(0, 1, 0, 1, 24'h000300, 32'hDEADBEEF, 4'hF, 3'd0);
    cycle();
    chk("t3_wr", 0, o_wr[0], 1'b1);
    chk("t3_wdata", 0, o_wdata[0], 32'hDEADBEEF);
    chk("t3_wstrb", 0, o_wstrb[0], 4'hF);
    m_ack[0] = 1'b1; m_done[0] = 1'b1;
    #1;
    chk("t3_ack", 0, ack_o[0], 3'b010);
    chk("t3_done", 0, done_o[0], 3'b010);
    cycle();
    clear_inputs();
    chk("t3_wr_after", 0, o_wr[0], 1'b0);
    chk("t3_grant_after", 0, grant_o[0], 3'b000);
    cycle();

    // burst mask 110 on dut0
    set_ch(0, 0, 1, 0, 24'h000400, 32'h0, 4'h0, 3'd4);
    cycle();
    chk("t4_blen_ch0", 0, o_blen[0], 3'd0);
    ack_done_cycle(0);
    clear_inputs();
    set_ch(0, 1, 1, 0, 24'h000500, 32'h0, 4'h0, 3'd4);
    cycle();
    chk("t4_blen_ch1", 0, o_blen[0], 3'd4);
    ack_done_cycle(0);
    clear_inputs();
    cycle();

    // round-robin fairness on dut1
    rd[1] = 3'b111;
    for (int t = 0; t < 5; t++) begin
      owner = -1;
      for (int k = 0; k < 8 && owner < 0; k++) begin
        cycle();
        if (grant_o[1] != '0) owner = $clog2(grant_o[1]);
      end
      chk("t2_rr_order", 1, owner, order[t]);
      ack_done_cycle(1);
    end
    clear_inputs();
    cycle();

    // reset while waiting for completion, then a stale done
    set_ch(0, 0, 1, 0, 24'h123456, 32'h0, 4'h0, 3'd0);
    cycle();
    m_ack[0] = 1'b1;
    cycle();
    m_ack[0] = 1'b0;
    clear_inputs();
    chk("t5_wait_grant", 0, grant_o[0], 3'b001);
    chk("t5_wait_addr", 0, o_addr[0], 24'h123456);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_grant", 0, grant_o[0], 3'b000);
    chk("t5_rst_addr", 0, o_addr[0], 24'h000000);
    chk("t5_rst_rd", 0, o_rd[0], 1'b0);
    cycle();
    reset_n = 1'b1;
    m_done[0] = 1'b1;
    #1;
    chk("t5_stale_done", 0, done_o[0], 3'b000);
    cycle();
    m_done[0] = 1'b0;
    cycle();
    chk("t5_after_grant", 0, grant_o[0], 3'b000);

    // randomized traffic against the model, with one reset in the middle
    clear_inputs();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset_n = 1'b0;
        model_reset();
      end
      if (i == 1503) reset_n = 1'b1;
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
